// File: rtl/cache_arbiter_if.sv
// Bundle of icache, dcache and memory line-port signals shared by cache_arbiter.
// The arbiter uses the slave view; the caches/memory side (or a bench) uses master.
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Serializes icache line reads and dcache reads/write-backs onto one memory line port,
// round-robin on conflict, with the granted request latched for the whole transaction.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  cache_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    s_idle,
    s_icache,
    s_dcache
  } state_t;

  state_t                state, next_state;
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_WIDTH-1:0] req_wdata;
  logic                  req_write;

  logic i_req, d_req;
  logic take_i, take_d;
  logic mem_read, mem_write, i_resp, d_resp;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    next_state = state;
    take_i     = 1'b0;
    take_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      s_idle: begin
        if (i_req && (!d_req || last_grant)) begin
          take_i     = 1'b1;
          next_state = s_icache;
        end else if (d_req) begin
          take_d     = 1'b1;
          next_state = s_dcache;
        end
      end
      s_icache: begin
        mem_read  = ~req_write;
        mem_write = req_write;
        if (bus.mem_resp) begin
          i_resp     = ~rst;
          next_state = s_idle;
        end
      end
      s_dcache: begin
        mem_read  = ~req_write;
        mem_write = req_write;
        if (bus.mem_resp) begin
          d_resp     = ~rst;
          next_state = s_idle;
        end
      end
      default: next_state = s_idle;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= s_idle;
      last_grant <= 1'b1;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_write  <= 1'b0;
    end else begin
      state <= next_state;
      if (take_i) begin
        req_addr   <= bus.i_addr;
        req_write  <= 1'b0;
        last_grant <= 1'b0;
      end else if (take_d) begin
        req_addr   <= bus.d_addr;
        req_wdata  <= bus.d_wdata;
        req_write  <= bus.d_write;  // write wins when read and write are both raised
        last_grant <= 1'b1;
      end
    end
  end

  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = req_addr;
  assign bus.mem_wdata = req_wdata;
  assign bus.i_resp    = i_resp;
  assign bus.d_resp    = d_resp;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule
